// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } clk_div_state_e;

    localparam int unsigned CLK_DIV_MIN_RATIO = 2;

    // Ratios below the minimum would collapse the low phase, so they saturate.
    function automatic logic [31:0] clk_div_clamp(input logic [31:0] ratio);
        return (ratio < CLK_DIV_MIN_RATIO) ? CLK_DIV_MIN_RATIO : ratio;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with registered, glitch-free output and
// ratio updates that only land on a period boundary.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_div_valid,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_ready,
    output logic             o_clk_div,
    output logic             o_clk_en,
    output logic             o_busy
);

    clk_div_state_e   state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] ratio, ratio_n;
    logic [DIV_W-1:0] pend_ratio, pend_ratio_n;
    logic             pend_vld, pend_vld_n;
    logic [DIV_W-1:0] offer_ratio;
    logic             xfer;
    logic             wrap;

    // High while the count sits in the first ceil(n/2) cycles of the period.
    function automatic logic high_phase(input logic [DIV_W-1:0] c,
                                        input logic [DIV_W-1:0] n);
        logic [DIV_W:0] half;
        half = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
        return {1'b0, c} < half;
    endfunction

    assign offer_ratio = DIV_W'(clk_div_clamp(32'(i_div_ratio)));
    assign xfer        = i_div_valid && o_div_ready;
    assign wrap        = (state == RUN) && (cnt == ratio - DIV_W'(1));

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ratio_n      = ratio;
        pend_ratio_n = pend_ratio;
        pend_vld_n   = pend_vld;
        case (state)
            STOPPED: begin
                cnt_n = '0;
                if (pend_vld) begin
                    ratio_n    = pend_ratio;
                    pend_vld_n = 1'b0;
                end else if (xfer) begin
                    pend_ratio_n = offer_ratio;
                    pend_vld_n   = 1'b1;
                end
                if (i_enable) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_n = '0;
                    // A ratio offered on the wrap cycle itself goes straight in.
                    if (pend_vld) begin
                        ratio_n    = pend_ratio;
                        pend_vld_n = 1'b0;
                    end else if (xfer) begin
                        ratio_n = offer_ratio;
                    end
                    if (!i_enable) begin
                        state_n = STOPPED;
                    end
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                    if (xfer) begin
                        pend_ratio_n = offer_ratio;
                        pend_vld_n   = 1'b1;
                    end
                end
            end
            default: state_n = STOPPED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= STOPPED;
            cnt         <= '0;
            ratio       <= DIV_W'(DIV_RST);
            pend_vld    <= 1'b0;
            o_clk_div   <= 1'b0;
            o_clk_en    <= 1'b0;
            o_busy      <= 1'b0;
            o_div_ready <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ratio       <= ratio_n;
            pend_vld    <= pend_vld_n;
            o_clk_div   <= (state_n == RUN) && high_phase(cnt_n, ratio_n);
            o_clk_en    <= (state_n == RUN) && (cnt_n == '0);
            o_busy      <= (state_n == RUN);
            o_div_ready <= !pend_vld_n;
        end
    end

    always_ff @(posedge i_clk) begin
        pend_ratio <= pend_ratio_n;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset, ratios, handshake stalls, stop/restart
// and mid-period reset, with hand-derived output sequences.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       div_valid;
    logic [7:0] div_ratio;
    logic       div_ready;
    logic       clk_div;
    logic       clk_en;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_div_prog #(.DIV_W(8), .DIV_RST(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_div_valid (div_valid),
        .i_div_ratio (div_ratio),
        .o_div_ready (div_ready),
        .o_clk_div   (clk_div),
        .o_clk_en    (clk_en),
        .o_busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One tick per character; checks o_clk_div and o_clk_en against the strings.
    task automatic run_pat(input string tag, input string clk_pat, input string en_pat);
        for (int i = 0; i < clk_pat.len(); i++) begin
            tick();
            chk({tag, "_clk"}, 32'(clk_div), 32'(clk_pat.getc(i) == "1"));
            chk({tag, "_en"},  32'(clk_en),  32'(en_pat.getc(i) == "1"));
        end
    endtask

    task automatic load_stopped(input logic [7:0] r);
        div_valid = 1'b1;
        div_ratio = r;
        tick();
        div_valid = 1'b0;
        tick();
    endtask

    task automatic run_until_stopped(input string tag);
        enable = 1'b0;
        for (int i = 0; i < 300 && busy; i++) tick();
        chk(tag, 32'(busy), 32'd0);
        chk({tag, "_clk"}, 32'(clk_div), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        div_valid = 1'b0;
        div_ratio = 8'd0;
        tick();
        tick();
        chk("rst_clk",   32'(clk_div),   32'd0);
        chk("rst_en",    32'(clk_en),    32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(div_ready), 32'd1);

        // Default ratio 2 straight out of reset.
        rst    = 1'b0;
        enable = 1'b1;
        run_pat("n2", "1010", "1010");
        enable = 1'b0;
        tick();
        chk("n2_stop_busy", 32'(busy), 32'd0);
        chk("n2_stop_clk",  32'(clk_div), 32'd0);

        // N=5 loaded while stopped: ready low for one cycle only.
        div_valid = 1'b1;
        div_ratio = 8'd5;
        tick();
        div_valid = 1'b0;
        chk("n5_ready_lo", 32'(div_ready), 32'd0);
        tick();
        chk("n5_ready_hi", 32'(div_ready), 32'd1);
        enable = 1'b1;
        run_pat("n5", "1110011100", "1000010000");
        enable = 1'b0;
        tick();
        chk("n5_stop_busy", 32'(busy), 32'd0);

        // Running at N=4, offer N=7 at cnt=1.
        load_stopped(8'd4);
        enable = 1'b1;
        run_pat("n4", "11", "10");
        div_valid = 1'b1;
        div_ratio = 8'd7;
        tick();
        div_valid = 1'b0;
        chk("n4_c2_clk",   32'(clk_div),   32'd0);
        chk("n4_c2_ready", 32'(div_ready), 32'd0);
        tick();
        chk("n4_c3_clk",   32'(clk_div),   32'd0);
        chk("n4_c3_ready", 32'(div_ready), 32'd0);
        tick();
        chk("n7_wrap_clk",   32'(clk_div),   32'd1);
        chk("n7_wrap_en",    32'(clk_en),    32'd1);
        chk("n7_wrap_ready", 32'(div_ready), 32'd1);
        run_pat("n7", "1110001", "0000001");
        run_until_stopped("n7_stop");

        // N=0 clamps to 2.
        load_stopped(8'd0);
        enable = 1'b1;
        run_pat("n0", "1010", "1010");
        enable = 1'b0;
        tick();
        chk("n0_stop_busy", 32'(busy), 32'd0);

        // Second offer while pending is stalled and dropped; N=3 stays.
        div_valid = 1'b1;
        div_ratio = 8'd3;
        tick();
        div_ratio = 8'd9;
        chk("stall_ready_lo", 32'(div_ready), 32'd0);
        tick();
        div_valid = 1'b0;
        chk("stall_ready_hi", 32'(div_ready), 32'd1);
        enable = 1'b1;
        run_pat("n3", "110110", "100100");
        enable = 1'b0;
        tick();
        chk("n3_stop_busy", 32'(busy), 32'd0);

        // N=1 clamps to 2.
        load_stopped(8'd1);
        enable = 1'b1;
        run_pat("n1", "1010", "1010");
        run_until_stopped("n1_stop");

        // N=6: drop enable at cnt=0, full period completes then stops.
        load_stopped(8'd6);
        enable = 1'b1;
        tick();
        chk("n6_c0_clk", 32'(clk_div), 32'd1);
        enable = 1'b0;
        run_pat("n6_drop", "11000", "00000");
        tick();
        chk("n6_stop_clk",  32'(clk_div), 32'd0);
        chk("n6_stop_busy", 32'(busy),    32'd0);
        tick();
        chk("n6_held_busy", 32'(busy), 32'd0);

        // Reassert enable in the last low cycle: no gap.
        enable = 1'b1;
        tick();
        enable = 1'b0;
        run_pat("n6_re", "11000", "00000");
        enable = 1'b1;
        tick();
        chk("n6_nogap_clk",  32'(clk_div), 32'd1);
        chk("n6_nogap_en",   32'(clk_en),  32'd1);
        chk("n6_nogap_busy", 32'(busy),    32'd1);

        // Switch to N=8 while running, then reset at cnt=2.
        div_valid = 1'b1;
        div_ratio = 8'd8;
        tick();
        div_valid = 1'b0;
        for (int i = 0; i < 20 && !clk_en; i++) tick();
        chk("n8_wrap_en", 32'(clk_en), 32'd1);
        tick();
        tick();
        chk("n8_c2_clk", 32'(clk_div), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_clk",   32'(clk_div),   32'd0);
        chk("mrst_en",    32'(clk_en),    32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_ready", 32'(div_ready), 32'd1);
        rst = 1'b0;
        run_pat("mrst_n2", "1010", "1010");

        // Offer N=3 on the wrap cycle: next period uses it, ready stays high.
        div_valid = 1'b1;
        div_ratio = 8'd3;
        tick();
        div_valid = 1'b0;
        chk("wx_clk",   32'(clk_div),   32'd1);
        chk("wx_ready", 32'(div_ready), 32'd1);
        run_pat("wx_n3", "101", "001");
        run_until_stopped("end_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
